// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_unit
//  Purpose  : Instruction-fetch front end. Holds the PC, a circular fetch
//             queue fed by a ready-handshaked instruction memory, and the
//             IF/ID register with stall hold and branch/jump redirect flush.
//  Options  : FETCH_PERF_EN adds fetched / ID-stall / flush counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     INST_W      = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned     QUEUE_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic [XLEN-1:0]                    imem_addr,
   output logic                               imem_req,
   input  logic                               imem_ready,
   input  logic [INST_W-1:0]                  imem_data,
   input  logic                               redirect_valid,
   input  logic [XLEN-1:0]                    redirect_pc,
   input  logic                               id_stall,
   output logic                               id_valid,
   output logic [XLEN-1:0]                    id_pc,
   output logic [XLEN-1:0]                    id_pc_4,
   output logic [INST_W-1:0]                  id_instruction,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]                        perf_fetched,
   output logic [31:0]                        perf_stall_cycles,
   output logic [31:0]                        perf_flushes
`endif
);

   localparam int unsigned c_PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned c_CNT_W = $clog2(QUEUE_DEPTH + 1);

   // Program counter and queue bookkeeping
   logic [XLEN-1:0]    r_pc;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;

   // Queue storage: one PC and one instruction per entry
   logic [XLEN-1:0]    r_q_pc   [QUEUE_DEPTH];
   logic [INST_W-1:0]  r_q_inst [QUEUE_DEPTH];

   // IF/ID register
   logic               r_id_valid;
   logic [XLEN-1:0]    r_id_pc;
   logic [XLEN-1:0]    r_id_pc_4;
   logic [INST_W-1:0]  r_id_inst;

   logic               w_full;
   logic               w_empty;
   logic               w_req;
   logic               w_push;
   logic               w_id_load;
   logic               w_pop;
   logic [XLEN-1:0]    w_pc_plus4;
   logic [XLEN-1:0]    w_head_pc;
   logic [INST_W-1:0]  w_head_inst;
   logic [XLEN-1:0]    w_redirect_target;
   logic               w_unused;

   // Occupancy-only request: ID stall never gates fetching, so the queue
   // keeps filling behind a stalled ID stage until it is full.
   assign w_full      = (r_count == c_CNT_W'(QUEUE_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_req       = !w_full && !rst;
   assign w_push      = w_req && imem_ready;
   assign w_id_load   = !r_id_valid || !id_stall;
   assign w_pop       = w_id_load && !w_empty;
   assign w_pc_plus4  = r_pc + XLEN'(4);
   assign w_head_pc   = r_q_pc[r_rptr];
   assign w_head_inst = r_q_inst[r_rptr];

   // Redirect targets are forced word aligned; the low bits are dropped.
   assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused          = ^redirect_pc[1:0];

   assign imem_addr      = r_pc;
   assign imem_req       = w_req;
   assign id_valid       = r_id_valid;
   assign id_pc          = r_id_pc;
   assign id_pc_4        = r_id_pc_4;
   assign id_instruction = r_id_inst;
   assign queue_count    = r_count;

   // Queue entry write; a fetch landing in a redirect cycle is dropped
   always_ff @(posedge clk) begin
      if (w_push && !redirect_valid) begin
         r_q_pc[r_wptr]   <= r_pc;
         r_q_inst[r_wptr] <= imem_data;
      end
   end

   // PC, queue pointers/occupancy and IF/ID register: rst > redirect > normal
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_id_valid <= 1'b0;
         r_id_pc    <= '0;
         r_id_pc_4  <= '0;
         r_id_inst  <= '0;
      end else if (redirect_valid) begin
         r_pc       <= w_redirect_target;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_id_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_pc   <= w_pc_plus4;
            r_wptr <= r_wptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= w_head_pc;
            r_id_pc_4  <= w_head_pc + XLEN'(4);
            r_id_inst  <= w_head_inst;
            r_rptr     <= r_rptr + c_PTR_W'(1);
         end else if (w_id_load) begin
            // ID is free but nothing is queued: bubble, payload holds
            r_id_valid <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flushes;

   // Free-running event counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
         r_perf_flushes <= '0;
      end else begin
         if (w_push && !redirect_valid) r_perf_fetched <= r_perf_fetched + 32'd1;
         if (r_id_valid && id_stall)     r_perf_stall   <= r_perf_stall + 32'd1;
         if (redirect_valid)             r_perf_flushes <= r_perf_flushes + 32'd1;
      end
   end

   assign perf_fetched      = r_perf_fetched;
   assign perf_stall_cycles = r_perf_stall;
   assign perf_flushes      = r_perf_flushes;
`endif

endmodule
`default_nettype wire
